instr_fetch: RTL and testbench

Instruction fetch and next-PC sequencer for the SimpleCPU core. It sits on the consumer side of the control unit's `Branch` output. It fetches a 32-bit instruction word from instruction memory through a request/ready handshake and presents the word, its `op`/`func` fields and `PC+4` to the decoder for one issue cycle. In that same cycle it resolves the next PC from the decoder's 2-bit `Branch` code.

---
 rtl/instr_fetch.sv | 59 +++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetches an instruction word over a req/ready handshake, issues it for one cycle and sequences the next PC.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  Branch,
  input  logic [31:0] ext_imm,
  input  logic [31:0] rs_data,
  output logic [31:0] retired,
  output logic        fault
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FAULT} state_t;
  state_t state, nxt;
  logic [31:0] next_pc;
  logic bad_jr;
  assign op = instr[31:26];
  assign func = instr[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = pc;
  // fault is sticky because FAULT is absorbing until reset
  always_comb begin
    bad_jr = Branch == 2'b11 && rs_data[1:0] != 2'b00;
    next_pc = Branch == 2'b00 ? pc_plus4 :
              Branch == 2'b01 ? pc_plus4 + (ext_imm << 2) :
              Branch == 2'b10 ? {pc_plus4[31:28], instr[25:0], 2'b00} : rs_data;
    nxt = state == IDLE  ? FETCH :
          state == FETCH ? (imem_ready ? ISSUE : FETCH) :
          state == ISSUE ? (bad_jr ? FAULT : FETCH) : FAULT;
    imem_req = state == FETCH;
    instr_valid = state == ISSUE;
    fault = state == FAULT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      retired <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH && imem_ready) instr <= imem_rdata;
      if (state == ISSUE) begin
        retired <= retired + 32'd1;
        if (!bad_jr) pc <= next_pc;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized transaction-level check of instr_fetch against a PC/retire reference model.
module tb_instr_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ready, instr_valid, fault;
  logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, ext_imm, rs_data, retired;
  logic [5:0] op, func;
  logic [1:0] Branch;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] ref_pc, ref_ret, ref_instr;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .func(func), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .Branch(Branch), .ext_imm(ext_imm), .rs_data(rs_data), .retired(retired),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] b, input logic [31:0] p,
                                             input logic [31:0] ins, input logic [31:0] imm,
                                             input logic [31:0] rs);
    logic [31:0] seq;
    seq = p + 32'd4;
    case (b)
      2'd0: return seq;
      2'd1: return seq + imm * 32'd4;
      2'd2: return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      default: return rs;
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    tick;
    tick;
    chk("rst_req", imem_req, 0);
    chk("rst_vld", instr_valid, 0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_ret", retired, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    #1 chk("idle_req", imem_req, 0);
    tick;
    ref_pc = RST_PC;
    ref_ret = 0;
    ref_instr = 0;
  endtask

  task automatic fetch(input int waits, input logic [31:0] data);
    chk("f_req", imem_req, 1);
    chk("f_addr", imem_addr, ref_pc);
    chk("f_vld", instr_valid, 0);
    chk("f_op", op, ref_instr[31:26]);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      tick;
      chk("w_req", imem_req, 1);
      chk("w_addr", imem_addr, ref_pc);
      chk("w_vld", instr_valid, 0);
      chk("w_instr", instr, ref_instr);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    tick;
    imem_ready = $urandom;
    imem_rdata = $urandom;
    ref_instr = data;
    chk("i_vld", instr_valid, 1);
    chk("i_req", imem_req, 0);
    chk("i_instr", instr, data);
    chk("i_op", op, data[31:26]);
    chk("i_func", func, data[5:0]);
    chk("i_pc", pc, ref_pc);
    chk("i_pc4", pc_plus4, ref_pc + 32'd4);
  endtask

  task automatic issue(input logic [1:0] b, input logic [31:0] imm, input logic [31:0] rs);
    logic bad;
    logic [31:0] np;
    Branch = b;
    ext_imm = imm;
    rs_data = rs;
    bad = b == 2'b11 && rs[1:0] != 2'b00;
    np = model_next(b, ref_pc, ref_instr, imm, rs);
    tick;
    Branch = 2'($urandom);
    ext_imm = $urandom;
    rs_data = $urandom;
    ref_ret++;
    if (!bad) ref_pc = np;
    chk("x_ret", retired, ref_ret);
    chk("x_pc", pc, ref_pc);
    chk("x_fault", fault, 32'(bad));
    chk("x_vld", instr_valid, 0);
  endtask

  task automatic jump_to(input logic [31:0] t);
    fetch(0, $urandom);
    issue(2'b11, $urandom, t);
  endtask

  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    Branch = '0;
    ext_imm = '0;
    rs_data = '0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      fetch(0, $urandom);
      issue(2'b00, $urandom, $urandom);
      chk("seq_addr", imem_addr, 32'(4 * (i + 1)));
    end
    chk("seq_ret", retired, 4);
    jump_to(32'h8);
    fetch(3, $urandom);
    issue(2'b00, 0, 0);
    jump_to(32'h10);
    fetch(0, $urandom);
    issue(2'b01, 32'hFFFF_FFFE, 0);
    chk("br_neg", imem_addr, 32'h0C);
    jump_to(32'h10);
    fetch(1, $urandom);
    issue(2'b01, 32'h3, 0);
    chk("br_pos", imem_addr, 32'h20);
    jump_to(32'h4000_0008);
    fetch(0, 32'h0800_0040);
    issue(2'b10, 0, 0);
    chk("jmp", imem_addr, 32'h4000_0100);
    fetch(0, $urandom);
    issue(2'b11, 0, 32'h0000_0200);
    chk("jr", imem_addr, 32'h200);
    jump_to(32'hFFFF_FFFC);
    fetch(0, $urandom);
    issue(2'b00, 0, 0);
    chk("wrap", imem_addr, 0);
    chk("wrap_fault", fault, 0);
    for (int i = 0; i < 300; i++) begin
      fetch($urandom_range(0, 3), $urandom);
      issue(2'($urandom), $urandom, $urandom & 32'hFFFF_FFFC);
    end
    chk("req_mid", imem_req, 1);
    imem_ready = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_pc", pc, RST_PC);
    chk("arst_ret", retired, 0);
    do_reset;
    jump_to(32'h300);
    fetch(2, $urandom);
    issue(2'b11, 0, 32'h0000_0202);
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'b1;
      tick;
      chk("flt_req", imem_req, 0);
      chk("flt_vld", instr_valid, 0);
      chk("flt_fault", fault, 1);
      chk("flt_pc", pc, 32'h300);
      chk("flt_ret", retired, ref_ret);
    end
    do_reset;
    fetch(0, $urandom);
    issue(2'b00, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
